uart_frame_bridge: RTL and testbench
====================================

Name: uart_frame_bridge

Overview:
- Parametrised bridge between the UART byte streams and a single-port frame buffer BRAM port.
- LOAD mode: assembles incoming rx bytes into pixels of configurable width and writes them to sequential addresses until a full frame is stored.
- DUMP mode: on command, reads the frame back and serialises each pixel into bytes for the UART transmitter.
- Sits between uart_rx/uart_tx and the image BRAM at top level; replaces the ad-hoc counters and edge logic there.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel; must be a multiple of 8 (8, 16, 24, 32); BYTES = PIXEL_WIDTH/8.
- IMG_WIDTH, 128, pixels per row.
- IMG_HEIGHT, 128, rows per frame.
- READ_LATENCY, 2, BRAM cycles from mem_addr to valid mem_rdata; legal range 1..4.
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width (derived; not overridden).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle pulse, rx_data valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  byte offered to transmitter
- tx_ready  input  1  transmitter can accept a byte
- dump_start  input  1  one-cycle pulse, request frame dump
- clear  input  1  one-cycle pulse, abort and rearm LOAD
- mem_addr  output  ADDR_WIDTH  BRAM address
- mem_wdata  output  PIXEL_WIDTH  BRAM write data
- mem_we  output  1  BRAM write enable
- mem_rdata  input  PIXEL_WIDTH  BRAM read data
- image_loaded  output  1  full frame present in BRAM
- busy  output  1  high in FETCH or SEND
- dump_done  output  1  one-cycle pulse after last byte of a dump
- rx_dropped  output  1  sticky: rx byte arrived outside LOAD

Behaviour:
- Reset (async assert, sync release): state LOAD; byte_idx 0; all outputs 0; mem_addr 0.
- N = IMG_WIDTH*IMG_HEIGHT pixels. Bytes are little-endian: byte 0 is pixel[7:0].

States:
- LOAD:
  - Each rx_valid shifts rx_data into pixel byte slot byte_idx.
  - On byte BYTES-1, mem_we=1 for exactly one cycle the next cycle, with mem_wdata = assembled pixel and mem_addr = current pixel index.
  - The pixel index increments after the write; byte_idx returns to 0.
  - The write of pixel N-1 sets image_loaded=1 in the same cycle mem_we is high; go to READY.
  - Back-to-back rx_valid (every cycle) is sustained with no loss.
- READY:
  - dump_start: mem_addr←0, go to FETCH, busy=1.
  - rx_valid: discarded, rx_dropped←1.
- FETCH:
  - Hold mem_addr for READ_LATENCY cycles.
  - Capture mem_rdata into the shift register on the cycle it is valid; go to SEND.
- SEND:
  - tx_valid=1 with tx_data = shift register low byte.
  - A transfer occurs on any cycle with tx_valid&tx_ready.
  - After a transfer: shift right 8; tx_valid is re-asserted the next cycle for the next byte (one idle cycle between bytes is allowed).
  - tx_valid and tx_data stay stable until the transfer.
  - After BYTES transfers:
    - if mem_addr==N-1: tx_valid←0, dump_done pulses 1 cycle, busy←0, go to READY;
    - else: mem_addr+1, go to FETCH.

Boundaries and priority:
- dump_start in LOAD, FETCH or SEND: ignored.
- Repeated dumps from READY are allowed; the frame is retained.
- clear (highest priority, any state) takes effect the next cycle:
  - state LOAD, index 0, byte_idx 0;
  - image_loaded, rx_dropped, tx_valid, busy, mem_we ← 0;
  - an in-flight byte is abandoned.
- clear and rx_valid in the same cycle: the rx byte is dropped and rx_dropped is not set.
- Partial pixel at clear: discarded.
- Pixel index wraps only via clear/reset, never by arithmetic overflow; N need not be a power of 2.
- rx_valid during FETCH/SEND: discarded, rx_dropped←1.
- Async reset mid-dump: all outputs return to reset values immediately.

Test Plan:
- Reset, PIXEL_WIDTH=8, 4x2 frame: 8 rx bytes 0x10..0x17 → 8 single-cycle writes at addr 0..7 with data 0x10..0x17; image_loaded rises with the addr-7 write.
- PIXEL_WIDTH=16, 2x2: bytes 34 12 78 56 BC 9A F0 DE → writes 0x1234@0, 0x5678@1, 0x9ABC@2, 0xDEF0@3; rx_valid on consecutive cycles is handled.
- Dump with BRAM model (READ_LATENCY=2, 16-bit, frame above) and tx_ready toggling randomly → tx byte stream 34 12 78 56 BC 9A F0 DE exactly; tx_data stable while stalled; dump_done 1 cycle after 0xDE transfers; second dump repeats the stream.
- dump_start during LOAD (after 3 of 8 bytes) → no FETCH, busy stays 0; load completes normally. Extra rx byte in READY → rx_dropped=1, BRAM unchanged.
- clear asserted during SEND of pixel 1 → tx_valid 0 next cycle, image_loaded 0, state LOAD addr 0; a new 8-byte load writes from addr 0.
- Async rst_in pulse mid-load (between clock edges) → all outputs 0 immediately; a subsequent full load succeeds from addr 0.

Source files
------------

// File: rtl/uart_frame_bridge.sv
// Bridges UART byte streams and a frame-buffer BRAM port: LOAD packs rx bytes into
// pixels and writes them sequentially; DUMP reads pixels back and serialises them LSB byte first.
module uart_frame_bridge #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMG_WIDTH    = 128,
  parameter int IMG_HEIGHT   = 128,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic                   dump_start,
  input  logic                   clear,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [PIXEL_WIDTH-1:0] mem_wdata,
  output logic                   mem_we,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic                   image_loaded,
  output logic                   busy,
  output logic                   dump_done,
  output logic                   rx_dropped
);

  localparam int BYTES = PIXEL_WIDTH / 8;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0]         LAST_BYTE = BW'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(NPIX - 1);
  localparam logic [2:0]            RD_LAT    = 3'(READ_LATENCY);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_FETCH, S_SEND} state_t;

  state_t                  state_q;
  logic [BW-1:0]           byte_idx_q;
  logic [ADDR_WIDTH-1:0]   pix_idx_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [PIXEL_WIDTH-1:0]  asm_q;
  logic [PIXEL_WIDTH-1:0]  assembled_d;
  logic [PIXEL_WIDTH-1:0]  shift_q;
  logic [PIXEL_WIDTH-1:0]  mem_wdata_q;
  logic [2:0]              lat_q;
  logic                    mem_we_q;
  logic                    image_loaded_q;
  logic                    busy_q;
  logic                    dump_done_q;
  logic                    rx_dropped_q;
  logic                    tx_valid_q;

  // Pixel as it will look once the current rx byte lands in its slot.
  always_comb begin
    assembled_d = asm_q;
    assembled_d[byte_idx_q*8 +: 8] = rx_data;
  end

  // tx handshake: a byte moves on any cycle with tx_valid & tx_ready; while tx_valid is
  // high and tx_ready low, tx_valid and tx_data hold. One idle cycle follows each transfer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= S_LOAD;
      byte_idx_q     <= '0;
      pix_idx_q      <= '0;
      mem_addr_q     <= '0;
      asm_q          <= '0;
      shift_q        <= '0;
      mem_wdata_q    <= '0;
      lat_q          <= '0;
      mem_we_q       <= 1'b0;
      image_loaded_q <= 1'b0;
      busy_q         <= 1'b0;
      dump_done_q    <= 1'b0;
      rx_dropped_q   <= 1'b0;
      tx_valid_q     <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      dump_done_q <= 1'b0;
      if (clear) begin
        state_q        <= S_LOAD;
        byte_idx_q     <= '0;
        pix_idx_q      <= '0;
        mem_addr_q     <= '0;
        asm_q          <= '0;
        image_loaded_q <= 1'b0;
        rx_dropped_q   <= 1'b0;
        tx_valid_q     <= 1'b0;
        busy_q         <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (rx_valid) begin
              if (byte_idx_q == LAST_BYTE) begin
                byte_idx_q  <= '0;
                asm_q       <= '0;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= assembled_d;
                mem_addr_q  <= pix_idx_q;
                if (pix_idx_q == LAST_PIX) begin
                  image_loaded_q <= 1'b1;
                  state_q        <= S_READY;
                end else begin
                  pix_idx_q <= pix_idx_q + 1'b1;
                end
              end else begin
                asm_q      <= assembled_d;
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end
          end
          S_READY: begin
            if (rx_valid) rx_dropped_q <= 1'b1;
            if (dump_start) begin
              mem_addr_q <= '0;
              lat_q      <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (rx_valid) rx_dropped_q <= 1'b1;
            // Read data is valid in the cycle after READ_LATENCY edges of a held address.
            if (lat_q == RD_LAT) begin
              shift_q    <= mem_rdata;
              tx_valid_q <= 1'b1;
              byte_idx_q <= '0;
              state_q    <= S_SEND;
            end else begin
              lat_q <= lat_q + 3'd1;
            end
          end
          S_SEND: begin
            if (rx_valid) rx_dropped_q <= 1'b1;
            if (tx_valid_q && tx_ready) begin
              shift_q    <= shift_q >> 8;
              tx_valid_q <= 1'b0;
              if (byte_idx_q == LAST_BYTE) begin
                byte_idx_q <= '0;
                if (mem_addr_q == LAST_PIX) begin
                  dump_done_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_READY;
                end else begin
                  mem_addr_q <= mem_addr_q + 1'b1;
                  lat_q      <= '0;
                  state_q    <= S_FETCH;
                end
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end else if (!tx_valid_q) begin
              tx_valid_q <= 1'b1;
            end
          end
          default: state_q <= S_LOAD;
        endcase
      end
    end
  end

  assign tx_data      = shift_q[7:0];
  assign tx_valid     = tx_valid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign image_loaded = image_loaded_q;
  assign busy         = busy_q;
  assign dump_done    = dump_done_q;
  assign rx_dropped   = rx_dropped_q;

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Directed bench: an 8-bit 4x2 bridge and a 16-bit 2x2 bridge with a 2-cycle BRAM model.
module tb_uart_frame_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 16-bit, 2x2 instance
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid16 = 1'b0, dump_start16 = 1'b0, clear16 = 1'b0;
  logic        tx_force = 1'b0, tx_rand = 1'b0, rnd_bit = 1'b0;
  logic        tx_ready16;
  logic [7:0]  tx_data16;
  logic        tx_valid16, mem_we16, image_loaded16, busy16, dump_done16, rx_dropped16;
  logic [1:0]  mem_addr16;
  logic [15:0] mem_wdata16, mem_rdata16;

  // 8-bit, 4x2 instance
  logic        rx_valid8 = 1'b0, dump_start8 = 1'b0, clear8 = 1'b0, tx_ready8 = 1'b0;
  logic [7:0]  mem_rdata8 = 8'h00;
  logic [7:0]  tx_data8, mem_wdata8;
  logic        tx_valid8, mem_we8, image_loaded8, busy8, dump_done8, rx_dropped8;
  logic [2:0]  mem_addr8;

  assign tx_ready16 = tx_rand ? rnd_bit : tx_force;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  uart_frame_bridge #(.PIXEL_WIDTH(16), .IMG_WIDTH(2), .IMG_HEIGHT(2), .READ_LATENCY(2)) u16 (
    .clk_in(clk), .rst_in(rst), .rx_data(rx_data), .rx_valid(rx_valid16),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .dump_start(dump_start16), .clear(clear16),
    .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_we(mem_we16), .mem_rdata(mem_rdata16),
    .image_loaded(image_loaded16), .busy(busy16), .dump_done(dump_done16), .rx_dropped(rx_dropped16)
  );

  uart_frame_bridge #(.PIXEL_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .READ_LATENCY(2)) u8 (
    .clk_in(clk), .rst_in(rst), .rx_data(rx_data), .rx_valid(rx_valid8),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .dump_start(dump_start8), .clear(clear8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_we(mem_we8), .mem_rdata(mem_rdata8),
    .image_loaded(image_loaded8), .busy(busy8), .dump_done(dump_done8), .rx_dropped(rx_dropped8)
  );

  // BRAM model with two read pipeline stages
  logic [15:0] mem16 [4];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_we16) mem16[mem_addr16] <= mem_wdata16;
    rd1 <= mem16[mem_addr16];
    rd2 <= rd1;
  end
  assign mem_rdata16 = rd2;

  // Observation logs: writes as {image_loaded, addr, data}, transferred tx bytes, dump_done timing
  logic [18:0] w16_q[$], exp16_q[$];
  logic [11:0] w8_q[$], exp8_q[$];
  logic [7:0]  tx_q[$];
  int cyc = 0, last_xfer = 0, done_cyc = 0, done_cnt = 0, stall_viol = 0;
  logic stall_track = 1'b0;
  logic [7:0] prev_tx = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we16) w16_q.push_back({image_loaded16, mem_addr16, mem_wdata16});
    if (mem_we8) w8_q.push_back({image_loaded8, mem_addr8, mem_wdata8});
    if (tx_valid16 && tx_ready16) begin
      tx_q.push_back(tx_data16);
      last_xfer <= cyc + 1;
    end
    if (dump_done16) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc + 1;
    end
    if (stall_track && (!tx_valid16 || tx_data16 !== prev_tx)) stall_viol <= stall_viol + 1;
    stall_track <= tx_valid16 && !tx_ready16;
    prev_tx     <= tx_data16;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_byte(input logic to16, input logic [7:0] b);
    @(negedge clk);
    rx_data    = b;
    rx_valid16 = to16;
    rx_valid8  = ~to16;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_valid16 = 1'b0;
    rx_valid8  = 1'b0;
  endtask

  task automatic check_w16(input string tag, input int base);
    logic [18:0] o;
    chk({tag, "_count"}, 64'(w16_q.size() - base), 64'(exp16_q.size()));
    for (int i = 0; i < exp16_q.size(); i++) begin
      o = (base + i < w16_q.size()) ? w16_q[base + i] : 19'h7ffff;
      chk($sformatf("%s_w%0d", tag, i), 64'(o), 64'(exp16_q[i]));
    end
    exp16_q.delete();
  endtask

  task automatic do_dump(input string tag);
    int b, d, s;
    logic [63:0] p;
    b = tx_q.size();
    d = done_cnt;
    s = stall_viol;
    tx_rand = 1'b1;
    @(negedge clk);
    dump_start16 = 1'b1;
    @(negedge clk);
    dump_start16 = 1'b0;
    chk({tag, "_busy_hi"}, 64'(busy16), 64'd1);
    for (int i = 0; i < 400 && done_cnt == d; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d), 64'd1);
    chk({tag, "_nbytes"}, 64'(tx_q.size() - b), 64'd8);
    p = '0;
    for (int i = 0; i < 8; i++) p = {p[55:0], (b + i < tx_q.size()) ? tx_q[b + i] : 8'hxx};
    chk({tag, "_stream"}, p, 64'h3412_7856_BC9A_F0DE);
    chk({tag, "_stall_stable"}, 64'(stall_viol - s), 64'd0);
    chk({tag, "_done_lag"}, 64'(done_cyc - last_xfer), 64'd1);
    chk({tag, "_idle"}, 64'({busy16, tx_valid16}), 64'd0);
    tx_rand = 1'b0;
  endtask

  initial begin
    int base, tb0, found;
    repeat (3) @(negedge clk);
    chk("reset16", 64'({tx_valid16, busy16, image_loaded16, mem_we16, dump_done16, rx_dropped16,
                        mem_addr16, mem_wdata16, tx_data16}), 64'd0);
    chk("reset8", 64'({tx_valid8, busy8, image_loaded8, mem_we8, dump_done8, rx_dropped8,
                       mem_addr8, mem_wdata8, tx_data8}), 64'd0);
    rst = 1'b0;

    // 8-bit frame, bytes back-to-back
    for (int i = 0; i < 8; i++) rx_byte(1'b0, 8'h10 + 8'(i));
    rx_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) exp8_q.push_back({(i == 7), 3'(i), 8'h10 + 8'(i)});
    chk("load8_count", 64'(w8_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("load8_w%0d", i), 64'((i < w8_q.size()) ? w8_q[i] : 12'hfff), 64'(exp8_q[i]));
    chk("load8_loaded", 64'(image_loaded8), 64'd1);

    // 16-bit frame with an ignored dump_start after three bytes
    base = w16_q.size();
    rx_byte(1'b1, 8'h34); rx_byte(1'b1, 8'h12); rx_byte(1'b1, 8'h78);
    @(negedge clk);
    rx_valid16   = 1'b0;
    dump_start16 = 1'b1;
    @(negedge clk);
    dump_start16 = 1'b0;
    @(negedge clk);
    chk("load_dump_ignored", 64'({busy16, image_loaded16}), 64'd0);
    rx_byte(1'b1, 8'h56); rx_byte(1'b1, 8'hBC); rx_byte(1'b1, 8'h9A);
    rx_byte(1'b1, 8'hF0); rx_byte(1'b1, 8'hDE);
    rx_idle();
    repeat (2) @(negedge clk);
    exp16_q.push_back({1'b0, 2'd0, 16'h1234});
    exp16_q.push_back({1'b0, 2'd1, 16'h5678});
    exp16_q.push_back({1'b0, 2'd2, 16'h9ABC});
    exp16_q.push_back({1'b1, 2'd3, 16'hDEF0});
    check_w16("load16", base);
    chk("load16_loaded", 64'({image_loaded16, busy16}), 64'b10);

    // Stray byte in READY
    rx_byte(1'b1, 8'hAA);
    rx_idle();
    @(negedge clk);
    chk("ready_dropped", 64'(rx_dropped16), 64'd1);
    chk("ready_no_write", 64'(w16_q.size() - base), 64'd4);
    chk("ready_bram", {mem16[0], mem16[1], mem16[2], mem16[3]}, 64'h1234_5678_9ABC_DEF0);

    do_dump("dump1");
    do_dump("dump2");
    chk("dump_keeps_frame", 64'(image_loaded16), 64'd1);

    // clear in SEND of pixel 1, with a same-cycle rx byte that must vanish
    tb0 = tx_q.size();
    tx_force = 1'b1;
    @(negedge clk);
    dump_start16 = 1'b1;
    @(negedge clk);
    dump_start16 = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (mem_addr16 == 2'd1 && tx_valid16) found = 1;
    end
    chk("clr_reach_px1", 64'(found), 64'd1);
    tx_force   = 1'b0;
    clear16    = 1'b1;
    rx_data    = 8'hEE;
    rx_valid16 = 1'b1;
    @(negedge clk);
    clear16    = 1'b0;
    rx_valid16 = 1'b0;
    chk("clr_outputs", 64'({tx_valid16, busy16, image_loaded16, rx_dropped16, mem_we16, mem_addr16}), 64'd0);
    chk("clr_tx_bytes", 64'(tx_q.size() - tb0), 64'd2);
    base = w16_q.size();
    for (int i = 1; i <= 8; i++) rx_byte(1'b1, 8'(i));
    rx_idle();
    repeat (2) @(negedge clk);
    exp16_q.push_back({1'b0, 2'd0, 16'h0201});
    exp16_q.push_back({1'b0, 2'd1, 16'h0403});
    exp16_q.push_back({1'b0, 2'd2, 16'h0605});
    exp16_q.push_back({1'b1, 2'd3, 16'h0807});
    check_w16("reload", base);
    chk("reload_flags", 64'({image_loaded16, rx_dropped16}), 64'b10);

    // Async reset between clock edges, mid-load
    @(negedge clk);
    clear16 = 1'b1;
    @(negedge clk);
    clear16 = 1'b0;
    for (int i = 0; i < 5; i++) rx_byte(1'b1, 8'hA0 + 8'(i));
    rx_idle();
    #2 rst = 1'b1;
    #1;
    chk("arst16", 64'({tx_valid16, busy16, image_loaded16, mem_we16, dump_done16, rx_dropped16,
                       mem_addr16, mem_wdata16, tx_data16}), 64'd0);
    chk("arst8", 64'({tx_valid8, busy8, image_loaded8, mem_we8, dump_done8, rx_dropped8,
                      mem_addr8, mem_wdata8, tx_data8}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = w16_q.size();
    for (int i = 0; i < 8; i++) rx_byte(1'b1, 8'h11 + 8'(i));
    rx_idle();
    repeat (2) @(negedge clk);
    exp16_q.push_back({1'b0, 2'd0, 16'h1211});
    exp16_q.push_back({1'b0, 2'd1, 16'h1413});
    exp16_q.push_back({1'b0, 2'd2, 16'h1615});
    exp16_q.push_back({1'b1, 2'd3, 16'h1817});
    check_w16("post_rst", base);
    chk("post_rst_loaded", 64'(image_loaded16), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
